log_engine_arbiter: RTL and testbench

//  Shares one iterative integer-log engine (start/enable/done, result g) among N requesters.

---
 rtl/log_engine_arbiter.sv | 174 +++++++++++++++++
 tb/tb_log_engine_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_engine_arbiter.sv
// Round-robin front end that shares one iterative integer-log engine among N clients.
// Rejects c<2 locally and bounds every engine run with a WAIT-state timeout.
module log_engine_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned W       = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_c,
    input  logic [N*W-1:0] req_j,
    output logic [N-1:0]   ack,
    output logic [W-1:0]   rsp_g,
    output logic           rsp_err,
    output logic           busy,
    output logic           eng_start,
    output logic           eng_enable,
    output logic [W-1:0]   eng_c,
    output logic [W-1:0]   eng_j,
    input  logic [W-1:0]   eng_g,
    input  logic           eng_done
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned TW = $clog2(TIMEOUT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]    state, state_nx;
    logic [IW-1:0] id, id_nx;
    logic [IW-1:0] rr_ptr, rr_ptr_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [N-1:0]  ack_nx;
    logic [W-1:0]  rsp_g_nx;
    logic          rsp_err_nx;
    logic          busy_nx;
    logic          eng_start_nx;
    logic          eng_enable_nx;
    logic [W-1:0]  eng_c_nx, eng_j_nx;

    logic [N-1:0]  eligible;
    logic          found;
    logic [IW-1:0] pick;
    logic [W-1:0]  pick_c, pick_j;
    int unsigned   scan_idx;

    // A requester still sees its ack while we are back in IDLE; never re-serve it then.
    assign eligible = req & ~ack;

    // Round-robin search starting at rr_ptr.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        scan_idx = 0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = 32'(rr_ptr) + k;
            if (scan_idx >= N) scan_idx = scan_idx - N;
            if (!found && eligible[IW'(scan_idx)]) begin
                found = 1'b1;
                pick  = IW'(scan_idx);
            end
        end
    end

    always_comb begin
        pick_c = '0;
        pick_j = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pick == IW'(i)) begin
                pick_c = req_c[i*W +: W];
                pick_j = req_j[i*W +: W];
            end
        end
    end

    always_comb begin
        state_nx      = state;
        id_nx         = id;
        rr_ptr_nx     = rr_ptr;
        timer_nx      = timer;
        ack_nx        = '0;
        rsp_g_nx      = rsp_g;
        rsp_err_nx    = rsp_err;
        eng_start_nx  = 1'b0;
        eng_enable_nx = eng_enable;
        eng_c_nx      = eng_c;
        eng_j_nx      = eng_j;
        case (state)
            IDLE: begin
                if (found) begin
                    id_nx     = pick;
                    rr_ptr_nx = (pick == IW'(N - 1)) ? '0 : pick + 1'b1;
                    if (pick_c < W'(2)) begin
                        state_nx   = RESP;
                        rsp_err_nx = 1'b1;
                        rsp_g_nx   = '0;
                    end else begin
                        state_nx      = ISSUE;
                        eng_c_nx      = pick_c;
                        eng_j_nx      = pick_j;
                        eng_start_nx  = 1'b1;
                        eng_enable_nx = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_nx      = WAIT;
                timer_nx      = '0;
                eng_enable_nx = 1'b1;
            end
            WAIT: begin
                eng_enable_nx = 1'b1;
                if (eng_done) begin
                    state_nx      = RESP;
                    rsp_g_nx      = eng_g;
                    rsp_err_nx    = 1'b0;
                    eng_enable_nx = 1'b0;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_nx      = RESP;
                    rsp_g_nx      = '0;
                    rsp_err_nx    = 1'b1;
                    eng_enable_nx = 1'b0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            RESP: begin
                state_nx      = IDLE;
                ack_nx[id]    = 1'b1;
                eng_enable_nx = 1'b0;
            end
            default: begin
                state_nx      = IDLE;
                eng_enable_nx = 1'b0;
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            id         <= '0;
            rr_ptr     <= '0;
            timer      <= '0;
            ack        <= '0;
            rsp_g      <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            eng_start  <= 1'b0;
            eng_enable <= 1'b0;
            eng_c      <= '0;
            eng_j      <= '0;
        end else begin
            state      <= state_nx;
            id         <= id_nx;
            rr_ptr     <= rr_ptr_nx;
            timer      <= timer_nx;
            ack        <= ack_nx;
            rsp_g      <= rsp_g_nx;
            rsp_err    <= rsp_err_nx;
            busy       <= busy_nx;
            eng_start  <= eng_start_nx;
            eng_enable <= eng_enable_nx;
            eng_c      <= eng_c_nx;
            eng_j      <= eng_j_nx;
        end
    end

endmodule

// File: tb/tb_log_engine_arbiter.sv
// Scoreboard bench for log_engine_arbiter: engine BFM, round-based request model, ack monitor.
module tb_log_engine_arbiter;

    localparam int unsigned N       = 4;
    localparam int unsigned W       = 16;
    localparam int unsigned TIMEOUT = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_c = '0;
    logic [N*W-1:0] req_j = '0;
    logic [N-1:0]   ack;
    logic [W-1:0]   rsp_g;
    logic           rsp_err;
    logic           busy;
    logic           eng_start;
    logic           eng_enable;
    logic [W-1:0]   eng_c;
    logic [W-1:0]   eng_j;
    logic [W-1:0]   eng_g = '0;
    logic           eng_done = 1'b0;

    log_engine_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_c(req_c), .req_j(req_j),
        .ack(ack), .rsp_g(rsp_g), .rsp_err(rsp_err), .busy(busy),
        .eng_start(eng_start), .eng_enable(eng_enable), .eng_c(eng_c), .eng_j(eng_j),
        .eng_g(eng_g), .eng_done(eng_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] ack;
        logic [W-1:0] g;
        logic         err;
    } exp_t;

    exp_t         expq[$];
    exp_t         mon_e;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           req_cyc = 0;
    int           last_ack_cyc = 0;
    int           ptr_model = 0;
    int           start_cnt = 0;
    logic [W-1:0] op_c [N];
    logic [W-1:0] op_j [N];

    // Engine BFM controls
    bit           bfm_never = 1'b0;
    int           bfm_lat = 0;
    int           poke_req = 0;
    int           poke_seen = 0;
    bit           bfm_active = 1'b0;
    int           bfm_cnt = 0;
    int           bfm_cur_lat = 1;

    always @(posedge clk) cyc <= cyc + 1;

    // Integer log: largest g with c**g < j (0 when j<=c); only meaningful for c>=2.
    function automatic logic [W-1:0] ilog(input logic [W-1:0] c, input logic [W-1:0] j);
        longint p;
        int     g;
        if (c < 2) return '0;
        p = longint'(c);
        g = 0;
        while (p < longint'(j)) begin
            g++;
            p = p * longint'(c);
        end
        return W'(g);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Engine BFM: done after a latency counted in enabled cycles after the start pulse.
    always @(negedge clk) begin
        if (reset) begin
            bfm_active = 1'b0;
            eng_done   = 1'b0;
        end else begin
            if (eng_done) eng_done = 1'b0;
            if (poke_seen != poke_req) begin
                poke_seen = poke_req;
                eng_done  = 1'b1;
                eng_g     = 16'hBEEF;
            end else if (eng_start) begin
                bfm_active  = 1'b1;
                bfm_cnt     = 0;
                start_cnt++;
                bfm_cur_lat = (bfm_lat == 0) ? int'($urandom_range(1, 8)) : bfm_lat;
            end else if (bfm_active && eng_enable) begin
                bfm_cnt++;
                if (!bfm_never && bfm_cnt == bfm_cur_lat) begin
                    eng_done   = 1'b1;
                    eng_g      = ilog(eng_c, eng_j);
                    bfm_active = 1'b0;
                end
            end else begin
                bfm_active = 1'b0;
            end
        end
    end

    // Monitor: every ack pops one expected response.
    always @(negedge clk) begin
        if (!reset && ack != '0) begin
            last_ack_cyc = cyc;
            if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got %b expected none", ack);
            end else begin
                mon_e = expq.pop_front();
                chk("ack", 32'(ack), 32'(mon_e.ack));
                chk("rsp_g", 32'(rsp_g), 32'(mon_e.g));
                chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                chk("eng_enable_at_ack", 32'(eng_enable), 32'(0));
            end
        end
    end

    task automatic rand_ops(input bit allow_reject);
        for (int i = 0; i < int'(N); i++) begin
            if (allow_reject && $urandom_range(0, 4) == 0) op_c[i] = W'($urandom_range(0, 1));
            else if ($urandom_range(0, 7) == 0)           op_c[i] = W'($urandom_range(2, 300));
            else                                           op_c[i] = W'($urandom_range(2, 12));
            op_j[i] = ($urandom_range(0, 5) == 0) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 65535));
        end
    endtask

    // Model: all requests of a round rise together, so service order is cyclic from the pointer.
    task automatic run_round(input logic [N-1:0] mask, input bit never, input int lat, input int exp_lat);
        int   id;
        int   last;
        int   starts;
        int   s0;
        bit   done_ok;
        exp_t e;
        bfm_never = never;
        bfm_lat   = lat;
        starts    = 0;
        last      = ptr_model;
        for (int k = 0; k < int'(N); k++) begin
            id = (ptr_model + k) % int'(N);
            if (mask[id]) begin
                e.ack     = '0;
                e.ack[id] = 1'b1;
                if (op_c[id] < 2 || never) begin
                    e.g   = '0;
                    e.err = 1'b1;
                end else begin
                    e.g   = ilog(op_c[id], op_j[id]);
                    e.err = 1'b0;
                end
                if (op_c[id] >= 2) starts++;
                expq.push_back(e);
                last = id;
            end
        end
        ptr_model = (last + 1) % int'(N);
        for (int i = 0; i < int'(N); i++) begin
            req_c[i*W +: W] = op_c[i];
            req_j[i*W +: W] = op_j[i];
        end
        s0 = start_cnt;
        @(negedge clk);
        req     = mask;
        req_cyc = cyc;
        done_ok = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            req = req & ~ack;
            if (req == '0) begin
                done_ok = 1'b1;
                break;
            end
        end
        if (!done_ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL round_timeout: pending %b expected none", req);
            req = '0;
        end
        @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'(0));
        chk("eng_start_count", 32'(start_cnt - s0), 32'(starts));
        chk("busy_after_round", 32'(busy), 32'(0));
        if (exp_lat > 0) chk("latency", 32'(last_ack_cyc - req_cyc), 32'(exp_lat));
        expq.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ack"}, 32'(ack), 32'(0));
        chk({tag, "_rsp_g"}, 32'(rsp_g), 32'(0));
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_eng_start"}, 32'(eng_start), 32'(0));
        chk({tag, "_eng_enable"}, 32'(eng_enable), 32'(0));
        chk({tag, "_eng_c"}, 32'(eng_c), 32'(0));
        chk({tag, "_eng_j"}, 32'(eng_j), 32'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        // All four held twice: 0,1,2,3 then again from 0
        rand_ops(1'b0);
        run_round(4'b1111, 1'b0, 0, 0);
        rand_ops(1'b0);
        run_round(4'b1111, 1'b0, 0, 0);

        // Single request c=2 j=9, engine done after 3 cycles
        rand_ops(1'b0);
        op_c[0] = 16'd2;
        op_j[0] = 16'd9;
        run_round(4'b0001, 1'b0, 3, 6);
        chk("g_c2_j9", 32'(rsp_g), 32'(3));

        // Degenerate base rejected locally
        op_c[2] = 16'd1;
        op_j[2] = 16'd50;
        run_round(4'b0100, 1'b0, 0, 2);

        // Engine never completes: timeout after TIMEOUT WAIT cycles
        op_c[1] = 16'd3;
        op_j[1] = 16'd100;
        run_round(4'b0010, 1'b1, 0, 3 + int'(TIMEOUT));

        // Reset in the middle of WAIT aborts silently and clears the pointer
        op_c[2] = 16'd5;
        op_j[2] = 16'd1000;
        for (int i = 0; i < int'(N); i++) begin
            req_c[i*W +: W] = op_c[i];
            req_j[i*W +: W] = op_j[i];
        end
        bfm_never = 1'b1;
        @(negedge clk);
        req = 4'b0100;
        repeat (5) @(negedge clk);
        chk("busy_in_wait", 32'(busy), 32'(1));
        chk("enable_in_wait", 32'(eng_enable), 32'(1));
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midop_reset");
        req   = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("no_ack_after_reset", 32'(ack), 32'(0));
        ptr_model = 0;
        rand_ops(1'b0);
        run_round(4'b1010, 1'b0, 0, 0);

        // Stray done while idle
        poke_req++;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk("busy_stray_done", 32'(busy), 32'(0));
            chk("ack_stray_done", 32'(ack), 32'(0));
        end

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            rand_ops(1'b1);
            run_round(N'($urandom_range(1, (1 << N) - 1)), ($urandom_range(0, 9) == 0), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
